dsp_simd_arbiter: RTL and testbench



---
 rtl/dsp_simd_arbiter.sv | 117 +++++++++++
 tb/tb_dsp_simd_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dsp_simd_arbiter.sv
// rtl/dsp_simd_arbiter.sv - round-robin arbiter sharing a two-lane 10x9 SIMD multiplier
module dsp_simd_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 simd_en,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*10-1:0]   req_a,
  input  logic [NREQ*9-1:0]    req_b,
  output logic [18:0]          z0,
  output logic                 z0_valid,
  output logic [IDW-1:0]       z0_id,
  output logic [18:0]          z1,
  output logic                 z1_valid,
  output logic [IDW-1:0]       z1_id,
  output logic [2:0]           inflight
);

  logic [IDW-1:0] ptr;
  logic           g0_v, g1_v;
  logic [IDW-1:0] g0_id, g1_id, last_id;
  logic [9:0]     a0, a1;
  logic [8:0]     b0, b1;
  int             scan_idx;

  logic [LATENCY-1:0] v0_q, v1_q;
  logic [18:0]        p0_q  [LATENCY];
  logic [18:0]        p1_q  [LATENCY];
  logic [IDW-1:0]     id0_q [LATENCY];
  logic [IDW-1:0]     id1_q [LATENCY];

  // Scan from ptr with wrap; first hit takes lane 0, second (SIMD only) lane 1.
  always_comb begin
    g0_v      = 1'b0;
    g1_v      = 1'b0;
    g0_id     = '0;
    g1_id     = '0;
    req_ready = '0;
    scan_idx  = 0;
    if (reset_n) begin
      for (int i = 0; i < NREQ; i++) begin
        scan_idx = (int'(ptr) + i) % NREQ;
        if (req_valid[scan_idx]) begin
          if (!g0_v) begin
            g0_v                = 1'b1;
            g0_id               = IDW'(scan_idx);
            req_ready[scan_idx] = 1'b1;
          end else if (simd_en && !g1_v) begin
            g1_v                = 1'b1;
            g1_id               = IDW'(scan_idx);
            req_ready[scan_idx] = 1'b1;
          end
        end
      end
    end
  end

  assign last_id = g1_v ? g1_id : g0_id;
  assign a0 = req_a[int'(g0_id)*10 +: 10];
  assign b0 = req_b[int'(g0_id)*9 +: 9];
  assign a1 = req_a[int'(g1_id)*10 +: 10];
  assign b1 = req_b[int'(g1_id)*9 +: 9];

  // Stage data only loads on a valid entry, so the last stage holds the previous result.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr      <= '0;
      v0_q     <= '0;
      v1_q     <= '0;
      inflight <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        p0_q[k]  <= '0;
        p1_q[k]  <= '0;
        id0_q[k] <= '0;
        id1_q[k] <= '0;
      end
    end else begin
      if (g0_v) ptr <= (int'(last_id) == NREQ - 1) ? '0 : last_id + 1'b1;
      v0_q[0] <= g0_v;
      v1_q[0] <= g1_v;
      if (g0_v) begin
        p0_q[0]  <= 19'(a0) * 19'(b0);
        id0_q[0] <= g0_id;
      end
      if (g1_v) begin
        p1_q[0]  <= 19'(a1) * 19'(b1);
        id1_q[0] <= g1_id;
      end
      for (int k = 1; k < LATENCY; k++) begin
        v0_q[k] <= v0_q[k-1];
        v1_q[k] <= v1_q[k-1];
        if (v0_q[k-1]) begin
          p0_q[k]  <= p0_q[k-1];
          id0_q[k] <= id0_q[k-1];
        end
        if (v1_q[k-1]) begin
          p1_q[k]  <= p1_q[k-1];
          id1_q[k] <= id1_q[k-1];
        end
      end
      inflight <= inflight + 3'(g0_v) + 3'(g1_v)
                  - 3'(v0_q[LATENCY-1]) - 3'(v1_q[LATENCY-1]);
    end
  end

  assign z0       = p0_q[LATENCY-1];
  assign z0_id    = id0_q[LATENCY-1];
  assign z0_valid = v0_q[LATENCY-1];
  assign z1       = p1_q[LATENCY-1];
  assign z1_id    = id1_q[LATENCY-1];
  assign z1_valid = v1_q[LATENCY-1];

endmodule

// File: tb/tb_dsp_simd_arbiter.sv
// tb/tb_dsp_simd_arbiter.sv - directed self-checking bench for dsp_simd_arbiter
module tb_dsp_simd_arbiter;

  logic        clk;
  logic        reset_n;
  logic        simd_en;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [39:0] req_a;
  logic [35:0] req_b;
  logic [18:0] z0, z1;
  logic        z0_valid, z1_valid;
  logic [1:0]  z0_id, z1_id;
  logic [2:0]  inflight;

  int passed;
  int fails;
  int total;

  dsp_simd_arbiter #(.NREQ(4), .IDW(2), .LATENCY(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .simd_en   (simd_en),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .z0        (z0),
    .z0_valid  (z0_valid),
    .z0_id     (z0_id),
    .z1        (z1),
    .z1_valid  (z1_valid),
    .z1_id     (z1_id),
    .inflight  (inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [9:0] a, input logic [8:0] b);
    req_a[i*10 +: 10] = a;
    req_b[i*9 +: 9]   = b;
  endtask

  initial begin
    passed    = 0;
    fails     = 0;
    total     = 0;
    reset_n   = 1'b0;
    simd_en   = 1'b1;
    req_valid = 4'hF;
    req_a     = '0;
    req_b     = '0;
    for (int i = 0; i < 4; i++) set_ops(i, 10'(i + 1), 9'(i + 2));

    // Reset held with everything requesting
    tick(); tick(); tick();
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_z0_valid", 32'(z0_valid), 32'h0);
    chk("rst_z1_valid", 32'(z1_valid), 32'h0);
    chk("rst_inflight", 32'(inflight), 32'h0);
    chk("rst_z0", 32'(z0), 32'h0);
    chk("rst_z1_id", 32'(z1_id), 32'h0);

    // First grants after release: req0 lane0, req1 lane1
    reset_n = 1'b1;
    #1;
    chk("t1_ready_first", 32'(req_ready), 32'h3);
    tick();
    chk("t1_ready_ptr2", 32'(req_ready), 32'hC);
    chk("t1_inflight", 32'(inflight), 32'd2);
    req_valid = 4'h0;
    #1;
    chk("t1_ready_idle", 32'(req_ready), 32'h0);
    tick();
    chk("t1_z0_valid", 32'(z0_valid), 32'h1);
    chk("t1_z0", 32'(z0), 32'd2);
    chk("t1_z0_id", 32'(z0_id), 32'd0);
    chk("t1_z1_valid", 32'(z1_valid), 32'h1);
    chk("t1_z1", 32'(z1), 32'd6);
    chk("t1_z1_id", 32'(z1_id), 32'd1);
    chk("t1_inflight_hold", 32'(inflight), 32'd2);
    tick();
    chk("t1_z0_drop", 32'(z0_valid), 32'h0);
    chk("t1_z0_hold", 32'(z0), 32'd2);
    chk("t1_inflight_zero", 32'(inflight), 32'd0);

    // Single requester 2: 3*5
    set_ops(2, 10'd3, 9'd5);
    req_valid = 4'h4;
    #1;
    chk("t2_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'h0;
    chk("t2_inflight1", 32'(inflight), 32'd1);
    chk("t2_z0_notyet", 32'(z0_valid), 32'h0);
    tick();
    chk("t2_z0_valid", 32'(z0_valid), 32'h1);
    chk("t2_z0", 32'(z0), 32'd15);
    chk("t2_z0_id", 32'(z0_id), 32'd2);
    chk("t2_z1_valid", 32'(z1_valid), 32'h0);
    chk("t2_inflight_out", 32'(inflight), 32'd1);
    tick();
    chk("t2_z0_done", 32'(z0_valid), 32'h0);
    chk("t2_inflight0", 32'(inflight), 32'd0);

    // All valid, SIMD, ptr=3: grants {3,0},{1,2},{3,0}
    set_ops(2, 10'd3, 9'd4);
    req_valid = 4'hF;
    #1;
    chk("t3_ready_30", 32'(req_ready), 32'h9);
    tick();
    chk("t3_ready_12", 32'(req_ready), 32'h6);
    chk("t3_inflight2", 32'(inflight), 32'd2);
    tick();
    chk("t3_ready_30b", 32'(req_ready), 32'h9);
    chk("t3_z0_id", 32'(z0_id), 32'd3);
    chk("t3_z0", 32'(z0), 32'd20);
    chk("t3_z1_id", 32'(z1_id), 32'd0);
    chk("t3_z1", 32'(z1), 32'd2);
    chk("t3_inflight4", 32'(inflight), 32'd4);
    tick();
    chk("t3_z0_id_b", 32'(z0_id), 32'd1);
    chk("t3_z0_b", 32'(z0), 32'd6);
    chk("t3_z1_id_b", 32'(z1_id), 32'd2);
    chk("t3_z1_b", 32'(z1), 32'd12);
    chk("t3_inflight4b", 32'(inflight), 32'd4);

    // Non-SIMD from ptr=1: one grant per cycle 1,2,3,0
    simd_en = 1'b0;
    #1;
    chk("t4_ready1", 32'(req_ready), 32'h2);
    tick();
    chk("t4_ready2", 32'(req_ready), 32'h4);
    chk("t4_z1_inflight_done", 32'(z1_valid), 32'h1);
    chk("t4_z1_id_30", 32'(z1_id), 32'd0);
    tick();
    chk("t4_ready3", 32'(req_ready), 32'h8);
    chk("t4_z0_id_1", 32'(z0_id), 32'd1);
    chk("t4_z1_off", 32'(z1_valid), 32'h0);
    tick();
    chk("t4_ready0", 32'(req_ready), 32'h1);
    chk("t4_z0_id_2", 32'(z0_id), 32'd2);
    chk("t4_z1_off2", 32'(z1_valid), 32'h0);
    tick();
    req_valid = 4'h0;
    chk("t4_z0_id_3", 32'(z0_id), 32'd3);
    chk("t4_z0_v3", 32'(z0_valid), 32'h1);
    tick();
    chk("t4_z0_id_0", 32'(z0_id), 32'd0);
    chk("t4_z0_val_0", 32'(z0), 32'd2);
    chk("t4_z1_off3", 32'(z1_valid), 32'h0);
    tick();
    chk("t4_drained", 32'(inflight), 32'd0);
    chk("t4_z0_idle", 32'(z0_valid), 32'h0);

    // Reset mid-flight discards results and restarts at req0
    simd_en   = 1'b1;
    req_valid = 4'h3;
    #1;
    chk("t6_ready", 32'(req_ready), 32'h3);
    tick();
    req_valid = 4'h0;
    chk("t6_inflight2", 32'(inflight), 32'd2);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("t6_inflight0", 32'(inflight), 32'd0);
    chk("t6_z0_clr", 32'(z0), 32'd0);
    tick();
    chk("t6_no_z0", 32'(z0_valid), 32'h0);
    chk("t6_no_z1", 32'(z1_valid), 32'h0);
    tick();
    chk("t6_no_z0b", 32'(z0_valid), 32'h0);
    chk("t6_inflight0b", 32'(inflight), 32'd0);

    // Max operands on lane 0, zero operand on lane 1
    set_ops(0, 10'h3FF, 9'h1FF);
    set_ops(1, 10'h000, 9'h1FF);
    req_valid = 4'h3;
    #1;
    chk("t5_ready", 32'(req_ready), 32'h3);
    tick();
    req_valid = 4'h0;
    tick();
    chk("t5_z0", 32'(z0), 32'h7FA01);
    chk("t5_z0_id", 32'(z0_id), 32'd0);
    chk("t5_z0_valid", 32'(z0_valid), 32'h1);
    chk("t5_z1", 32'(z1), 32'd0);
    chk("t5_z1_id", 32'(z1_id), 32'd1);
    chk("t5_z1_valid", 32'(z1_valid), 32'h1);
    tick();
    chk("t5_inflight0", 32'(inflight), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
